// File: rtl/rob_param.sv
// Reorder buffer: in-order commit, CDB writeback, read-port bypass, flush on mispredict/exception.
// Define ROB_DUAL_CDB_EN to add the second CDB writeback port (CDB2_*).
module rob_param #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              VALID_Inst,
    input  logic [11:0]       Decoded_opcode,
    input  logic [4:0]        Decoded_Rd,
    input  logic              Decoded_prediction,
    output logic [TAG_W-1:0]  Alloc_ROBEN,
    input  logic [TAG_W-1:0]  CDB_ROBEN,
    input  logic [DATA_W-1:0] CDB_ROBEN_Write_Data,
    input  logic              CDB_Branch_Decision,
    input  logic              CDB_Exception,
`ifdef ROB_DUAL_CDB_EN
    input  logic [TAG_W-1:0]  CDB2_ROBEN,
    input  logic [DATA_W-1:0] CDB2_ROBEN_Write_Data,
    input  logic              CDB2_Branch_Decision,
    input  logic              CDB2_Exception,
`endif
    input  logic [TAG_W-1:0]  RP1_ROBEN1,
    input  logic [TAG_W-1:0]  RP1_ROBEN2,
    output logic [DATA_W-1:0] RP1_Write_Data1,
    output logic [DATA_W-1:0] RP1_Write_Data2,
    output logic              RP1_Ready1,
    output logic              RP1_Ready2,
    output logic              FULL_FLAG,
    output logic              EMPTY_FLAG,
    output logic              Commit_Valid,
    output logic [11:0]       Commit_opcode,
    output logic [4:0]        Commit_Rd,
    output logic [DATA_W-1:0] Commit_Write_Data,
    output logic [TAG_W-1:0]  Commit_ROBEN,
    output logic              FLUSH_Flag,
    output logic              EXCEPTION_Flag,
    output logic [TAG_W-1:0]  Start_Index,
    output logic [TAG_W-1:0]  End_Index
);

    localparam logic [TAG_W-1:0] LAST  = TAG_W'(DEPTH);
    localparam int               CNT_W = $clog2(DEPTH) + 1;

    logic              r_busy  [1:DEPTH];
    logic              r_ready [1:DEPTH];
    logic [11:0]       r_op    [1:DEPTH];
    logic [4:0]        r_rd    [1:DEPTH];
    logic [DATA_W-1:0] r_data  [1:DEPTH];
    logic              r_pred  [1:DEPTH];
    logic              r_dec   [1:DEPTH];
    logic              r_exc   [1:DEPTH];

    logic [TAG_W-1:0]  r_head, r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_cv, r_flush, r_excf;
    logic [11:0]       r_c_op;
    logic [4:0]        r_c_rd;
    logic [DATA_W-1:0] r_c_data;
    logic [TAG_W-1:0]  r_c_tag;

    logic [TAG_W-1:0]  w_cdb_tag  [2];
    logic [DATA_W-1:0] w_cdb_data [2];
    logic              w_cdb_dec  [2];
    logic              w_cdb_exc  [2];
    logic              w_cdb_we   [2];
    logic [TAG_W-1:0]  w_rp_tag   [2];
    logic [DATA_W-1:0] w_rp_data  [2];
    logic              w_rp_rdy   [2];

    logic w_full, w_empty, w_issue, w_commit;
    logic w_branch, w_misp, w_hexc, w_flush;

    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && (t <= LAST);
    endfunction

    function automatic logic [TAG_W-1:0] nxt(input logic [TAG_W-1:0] p);
        return (p == LAST) ? TAG_W'(1) : p + TAG_W'(1);
    endfunction

    assign w_cdb_tag[0]  = CDB_ROBEN;
    assign w_cdb_data[0] = CDB_ROBEN_Write_Data;
    assign w_cdb_dec[0]  = CDB_Branch_Decision;
    assign w_cdb_exc[0]  = CDB_Exception;
`ifdef ROB_DUAL_CDB_EN
    assign w_cdb_tag[1]  = CDB2_ROBEN;
    assign w_cdb_data[1] = CDB2_ROBEN_Write_Data;
    assign w_cdb_dec[1]  = CDB2_Branch_Decision;
    assign w_cdb_exc[1]  = CDB2_Exception;
`else
    assign w_cdb_tag[1]  = '0;
    assign w_cdb_data[1] = '0;
    assign w_cdb_dec[1]  = 1'b0;
    assign w_cdb_exc[1]  = 1'b0;
`endif

    assign w_cdb_we[0] = tag_ok(w_cdb_tag[0]) && r_busy[w_cdb_tag[0]];
    assign w_cdb_we[1] = tag_ok(w_cdb_tag[1]) && r_busy[w_cdb_tag[1]];

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_issue  = VALID_Inst && !w_full;
    assign w_commit = r_busy[r_head] && r_ready[r_head];

    // Opcode layout: [6:0] RV major opcode, [9:7] funct3; beq=000, bne=001
    assign w_branch = (r_op[r_head][6:0] == 7'b1100011) && (r_op[r_head][9:8] == 2'b00);
    assign w_misp   = w_branch && (r_dec[r_head] != r_pred[r_head]);
    assign w_hexc   = r_exc[r_head];
    assign w_flush  = w_commit && (w_hexc || w_misp);

    assign w_rp_tag[0] = RP1_ROBEN1;
    assign w_rp_tag[1] = RP1_ROBEN2;

    // Port 1 is applied last so it takes priority on a shared tag
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rp_data[p] = '0;
            w_rp_rdy[p]  = 1'b0;
            if (tag_ok(w_rp_tag[p]) && r_busy[w_rp_tag[p]]) begin
                if (r_ready[w_rp_tag[p]]) begin
                    w_rp_data[p] = r_data[w_rp_tag[p]];
                    w_rp_rdy[p]  = 1'b1;
                end
                for (int k = 1; k >= 0; k--) begin
                    if (w_cdb_we[k] && (w_cdb_tag[k] == w_rp_tag[p])) begin
                        w_rp_data[p] = w_cdb_data[k];
                        w_rp_rdy[p]  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= DEPTH; i++) begin
                r_busy[i]  <= 1'b0;
                r_ready[i] <= 1'b0;
            end
            r_head   <= TAG_W'(1);
            r_tail   <= TAG_W'(1);
            r_count  <= '0;
            r_cv     <= 1'b0;
            r_flush  <= 1'b0;
            r_excf   <= 1'b0;
            r_c_op   <= '0;
            r_c_rd   <= '0;
            r_c_data <= '0;
            r_c_tag  <= '0;
        end else begin
            r_cv    <= w_commit && !w_hexc;
            r_flush <= w_commit && !w_hexc && w_misp;
            r_excf  <= w_commit && w_hexc;
            if (w_commit) begin
                r_c_op   <= r_op[r_head];
                r_c_rd   <= r_rd[r_head];
                r_c_data <= r_data[r_head];
                r_c_tag  <= r_head;
            end
            if (w_flush) begin
                for (int i = 1; i <= DEPTH; i++) r_busy[i] <= 1'b0;
                r_head  <= TAG_W'(1);
                r_tail  <= TAG_W'(1);
                r_count <= '0;
            end else begin
                for (int k = 0; k < 2; k++)
                    if (w_cdb_we[k]) r_ready[w_cdb_tag[k]] <= 1'b1;
                if (w_issue) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= nxt(r_tail);
                end
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= nxt(r_head);
                end
                if (w_issue && !w_commit)      r_count <= r_count + CNT_W'(1);
                else if (!w_issue && w_commit) r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Payload needs no reset: it is only observed through busy/ready
    always_ff @(posedge clk) begin
        if (!w_flush) begin
            if (w_issue) begin
                r_op[r_tail]   <= Decoded_opcode;
                r_rd[r_tail]   <= Decoded_Rd;
                r_pred[r_tail] <= Decoded_prediction;
            end
            for (int k = 1; k >= 0; k--) begin
                if (w_cdb_we[k]) begin
                    r_data[w_cdb_tag[k]] <= w_cdb_data[k];
                    r_dec[w_cdb_tag[k]]  <= w_cdb_dec[k];
                    r_exc[w_cdb_tag[k]]  <= w_cdb_exc[k];
                end
            end
        end
    end

    assign Alloc_ROBEN       = r_tail;
    assign Start_Index       = r_head;
    assign End_Index         = r_tail;
    assign FULL_FLAG         = w_full;
    assign EMPTY_FLAG        = w_empty;
    assign Commit_Valid      = r_cv;
    assign Commit_opcode     = r_c_op;
    assign Commit_Rd         = r_c_rd;
    assign Commit_Write_Data = r_c_data;
    assign Commit_ROBEN      = r_c_tag;
    assign FLUSH_Flag        = r_flush;
    assign EXCEPTION_Flag    = r_excf;
    assign RP1_Write_Data1   = w_rp_data[0];
    assign RP1_Write_Data2   = w_rp_data[1];
    assign RP1_Ready1        = w_rp_rdy[0];
    assign RP1_Ready2        = w_rp_rdy[1];

endmodule

// File: tb/tb_rob_param.sv
// Directed testbench for rob_param (DEPTH=16); dual-CDB case built with ROB_DUAL_CDB_EN.
module tb_rob_param;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;

    localparam logic [11:0] OP_ADD = 12'h033;
    localparam logic [11:0] OP_BNE = 12'h0E3;

    logic              clk = 1'b0;
    logic              rst;
    logic              VALID_Inst;
    logic [11:0]       Decoded_opcode;
    logic [4:0]        Decoded_Rd;
    logic              Decoded_prediction;
    logic [TAG_W-1:0]  Alloc_ROBEN;
    logic [TAG_W-1:0]  CDB_ROBEN;
    logic [DATA_W-1:0] CDB_ROBEN_Write_Data;
    logic              CDB_Branch_Decision;
    logic              CDB_Exception;
`ifdef ROB_DUAL_CDB_EN
    logic [TAG_W-1:0]  CDB2_ROBEN;
    logic [DATA_W-1:0] CDB2_ROBEN_Write_Data;
    logic              CDB2_Branch_Decision;
    logic              CDB2_Exception;
`endif
    logic [TAG_W-1:0]  RP1_ROBEN1, RP1_ROBEN2;
    logic [DATA_W-1:0] RP1_Write_Data1, RP1_Write_Data2;
    logic              RP1_Ready1, RP1_Ready2;
    logic              FULL_FLAG, EMPTY_FLAG;
    logic              Commit_Valid;
    logic [11:0]       Commit_opcode;
    logic [4:0]        Commit_Rd;
    logic [DATA_W-1:0] Commit_Write_Data;
    logic [TAG_W-1:0]  Commit_ROBEN;
    logic              FLUSH_Flag, EXCEPTION_Flag;
    logic [TAG_W-1:0]  Start_Index, End_Index;

    int checks   = 0;
    int failures = 0;

    rob_param #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .VALID_Inst(VALID_Inst),
        .Decoded_opcode(Decoded_opcode),
        .Decoded_Rd(Decoded_Rd),
        .Decoded_prediction(Decoded_prediction),
        .Alloc_ROBEN(Alloc_ROBEN),
        .CDB_ROBEN(CDB_ROBEN),
        .CDB_ROBEN_Write_Data(CDB_ROBEN_Write_Data),
        .CDB_Branch_Decision(CDB_Branch_Decision),
        .CDB_Exception(CDB_Exception),
`ifdef ROB_DUAL_CDB_EN
        .CDB2_ROBEN(CDB2_ROBEN),
        .CDB2_ROBEN_Write_Data(CDB2_ROBEN_Write_Data),
        .CDB2_Branch_Decision(CDB2_Branch_Decision),
        .CDB2_Exception(CDB2_Exception),
`endif
        .RP1_ROBEN1(RP1_ROBEN1), .RP1_ROBEN2(RP1_ROBEN2),
        .RP1_Write_Data1(RP1_Write_Data1), .RP1_Write_Data2(RP1_Write_Data2),
        .RP1_Ready1(RP1_Ready1), .RP1_Ready2(RP1_Ready2),
        .FULL_FLAG(FULL_FLAG), .EMPTY_FLAG(EMPTY_FLAG),
        .Commit_Valid(Commit_Valid),
        .Commit_opcode(Commit_opcode),
        .Commit_Rd(Commit_Rd),
        .Commit_Write_Data(Commit_Write_Data),
        .Commit_ROBEN(Commit_ROBEN),
        .FLUSH_Flag(FLUSH_Flag), .EXCEPTION_Flag(EXCEPTION_Flag),
        .Start_Index(Start_Index), .End_Index(End_Index)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cdb(input int tag, input int data, input logic dec, input logic exc);
        CDB_ROBEN            = TAG_W'(tag);
        CDB_ROBEN_Write_Data = DATA_W'(data);
        CDB_Branch_Decision  = dec;
        CDB_Exception        = exc;
    endtask

    initial begin
        rst = 1'b1;
        VALID_Inst = 1'b0;
        Decoded_opcode = OP_ADD;
        Decoded_Rd = '0;
        Decoded_prediction = 1'b0;
        cdb(0, 0, 1'b0, 1'b0);
`ifdef ROB_DUAL_CDB_EN
        CDB2_ROBEN = '0;
        CDB2_ROBEN_Write_Data = '0;
        CDB2_Branch_Decision = 1'b0;
        CDB2_Exception = 1'b0;
`endif
        RP1_ROBEN1 = '0;
        RP1_ROBEN2 = '0;
        tick();
        tick();
        chk("rst_empty", EMPTY_FLAG, 1);
        chk("rst_full", FULL_FLAG, 0);
        chk("rst_start", Start_Index, 1);
        chk("rst_end", End_Index, 1);
        chk("rst_cv", Commit_Valid, 0);
        chk("rst_flush", FLUSH_Flag, 0);
        chk("rst_exc", EXCEPTION_Flag, 0);
        rst = 1'b0;

        // two adds
        VALID_Inst = 1'b1;
        Decoded_Rd = 5'd10;
        chk("alloc1", Alloc_ROBEN, 1);
        tick();
        Decoded_Rd = 5'd15;
        chk("alloc2", Alloc_ROBEN, 2);
        tick();
        VALID_Inst = 1'b0;
        chk("end3", End_Index, 3);
        chk("notempty", EMPTY_FLAG, 0);

        // out-of-order writeback, in-order commit
        cdb(2, 456, 1'b0, 1'b0);
        tick();
        cdb(1, 123, 1'b0, 1'b0);
        chk("nocommit_a", Commit_Valid, 0);
        tick();
        cdb(0, 0, 1'b0, 1'b0);
        chk("nocommit_b", Commit_Valid, 0);
        tick();
        chk("c1_valid", Commit_Valid, 1);
        chk("c1_rd", Commit_Rd, 10);
        chk("c1_data", Commit_Write_Data, 123);
        chk("c1_tag", Commit_ROBEN, 1);
        tick();
        chk("c2_valid", Commit_Valid, 1);
        chk("c2_rd", Commit_Rd, 15);
        chk("c2_data", Commit_Write_Data, 456);
        tick();
        chk("c_done", Commit_Valid, 0);
        chk("c_empty", EMPTY_FLAG, 1);
        chk("c_start", Start_Index, 3);

        // bne mispredict
        VALID_Inst = 1'b1;
        Decoded_opcode = OP_BNE;
        Decoded_Rd = 5'd0;
        Decoded_prediction = 1'b1;
        chk("alloc_bne", Alloc_ROBEN, 3);
        tick();
        VALID_Inst = 1'b0;
        Decoded_opcode = OP_ADD;
        Decoded_prediction = 1'b0;
        cdb(3, 0, 1'b0, 1'b0);
        tick();
        cdb(0, 0, 1'b0, 1'b0);
        chk("fl_pre", FLUSH_Flag, 0);
        tick();
        chk("fl_pulse", FLUSH_Flag, 1);
        chk("fl_start", Start_Index, 1);
        chk("fl_end", End_Index, 1);
        chk("fl_empty", EMPTY_FLAG, 1);
        tick();
        chk("fl_drop", FLUSH_Flag, 0);

        // fill to full, 17th issue ignored
        VALID_Inst = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            Decoded_Rd = 5'(i);
            tick();
        end
        chk("full_pre", FULL_FLAG, 0);
        Decoded_Rd = 5'd16;
        tick();
        chk("full", FULL_FLAG, 1);
        chk("full_end", End_Index, 1);
        Decoded_Rd = 5'd17;
        tick();
        chk("full_17", FULL_FLAG, 1);
        chk("full_17_end", End_Index, 1);
        chk("full_17_start", Start_Index, 1);
        VALID_Inst = 1'b0;

        // read port bypass
        RP1_ROBEN1 = 5'd4;
        RP1_ROBEN2 = 5'd4;
        #1;
        chk("rp_nr_rdy", RP1_Ready1, 0);
        chk("rp_nr_data", RP1_Write_Data1, 0);
        cdb(4, 999, 1'b0, 1'b0);
        #1;
        chk("rp_byp_data", RP1_Write_Data1, 999);
        chk("rp_byp_rdy", RP1_Ready1, 1);
        tick();
        cdb(0, 0, 1'b0, 1'b0);
        RP1_ROBEN2 = '0;
        #1;
        chk("rp_st_data", RP1_Write_Data1, 999);
        chk("rp_st_rdy", RP1_Ready1, 1);
        chk("rp_t0_data", RP1_Write_Data2, 0);
        chk("rp_t0_rdy", RP1_Ready2, 0);

        // issue while full in the same cycle as a commit
        cdb(1, 7, 1'b0, 1'b0);
        tick();
        cdb(0, 0, 1'b0, 1'b0);
        VALID_Inst = 1'b1;
        tick();
        VALID_Inst = 1'b0;
        chk("fc_cv", Commit_Valid, 1);
        chk("fc_tag", Commit_ROBEN, 1);
        chk("fc_data", Commit_Write_Data, 7);
        chk("fc_full", FULL_FLAG, 0);
        chk("fc_end", End_Index, 1);
        chk("fc_start", Start_Index, 2);

        // exception at head; issue and CDB in flush cycle discarded
        cdb(2, 5, 1'b0, 1'b1);
        tick();
        cdb(3, 77, 1'b0, 1'b0);
        VALID_Inst = 1'b1;
        tick();
        VALID_Inst = 1'b0;
        cdb(0, 0, 1'b0, 1'b0);
        RP1_ROBEN1 = 5'd3;
        #1;
        chk("ex_flag", EXCEPTION_Flag, 1);
        chk("ex_cv", Commit_Valid, 0);
        chk("ex_flush", FLUSH_Flag, 0);
        chk("ex_start", Start_Index, 1);
        chk("ex_end", End_Index, 1);
        chk("ex_empty", EMPTY_FLAG, 1);
        chk("ex_rp_rdy", RP1_Ready1, 0);
        tick();
        chk("ex_drop", EXCEPTION_Flag, 0);

        // CDB write to non-busy tag ignored
        cdb(9, 55, 1'b0, 1'b0);
        RP1_ROBEN1 = 5'd9;
        #1;
        chk("nb_byp_rdy", RP1_Ready1, 0);
        tick();
        cdb(0, 0, 1'b0, 1'b0);
        chk("nb_rdy", RP1_Ready1, 0);

        // asynchronous reset mid-operation
        VALID_Inst = 1'b1;
        tick();
        tick();
        VALID_Inst = 1'b0;
        chk("ar_pre_end", End_Index, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_end", End_Index, 1);
        chk("ar_start", Start_Index, 1);
        chk("ar_empty", EMPTY_FLAG, 1);
        tick();
        rst = 1'b0;

`ifdef ROB_DUAL_CDB_EN
        VALID_Inst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        VALID_Inst = 1'b0;
        cdb(5, 111, 1'b0, 1'b0);
        CDB2_ROBEN = 5'd5;
        CDB2_ROBEN_Write_Data = 32'd222;
        RP1_ROBEN1 = 5'd5;
        #1;
        chk("dual_byp", RP1_Write_Data1, 111);
        tick();
        cdb(0, 0, 1'b0, 1'b0);
        CDB2_ROBEN = '0;
        #1;
        chk("dual_st", RP1_Write_Data1, 111);
        chk("dual_rdy", RP1_Ready1, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rob_param.md
ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, meaning number of entries (power of two, 4..64).
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning result width.
REQ-003 The module SHALL have parameter TAG_W, default $clog2(DEPTH)+1, meaning ROBEN width (tag 0 = none, entries 1..DEPTH).
REQ-004 The module SHALL have these ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- VALID_Inst  in  1  issue request.
- Decoded_opcode  in  12  opcode.
- Decoded_Rd  in  5  destination register.
- Decoded_prediction  in  1  branch prediction.
- Alloc_ROBEN  out  TAG_W  tag given to the current issue.
- CDB_ROBEN  in  TAG_W  writeback tag (0 = idle).
- CDB_ROBEN_Write_Data  in  DATA_W  writeback data.
- CDB_Branch_Decision  in  1  resolved branch outcome.
- CDB_Exception  in  1  writeback exception.
- CDB2_ROBEN, CDB2_ROBEN_Write_Data, CDB2_Branch_Decision, CDB2_Exception  in  as above  second writeback port (macro-gated).
- RP1_ROBEN1, RP1_ROBEN2  in  TAG_W  read tags.
- RP1_Write_Data1, RP1_Write_Data2  out  DATA_W  read data.
- RP1_Ready1, RP1_Ready2  out  1  read ready.
- FULL_FLAG, EMPTY_FLAG  out  1  occupancy.
- Commit_Valid  out  1  one-cycle commit strobe.
- Commit_opcode  out  12  committed opcode.
- Commit_Rd  out  5  committed Rd.
- Commit_Write_Data  out  DATA_W  committed data.
- Commit_ROBEN  out  TAG_W  committed tag.
- FLUSH_Flag  out  1  mispredict flush pulse.
- EXCEPTION_Flag  out  1  exception pulse.
- Start_Index, End_Index  out  TAG_W  head/tail tags.

Function
REQ-005 Circular buffer of DEPTH entries SHALL hold busy, opcode, rd, data, ready, prediction, decision, exception; head = Start_Index, tail = End_Index, both 1-based, wrapping DEPTH->1.
REQ-006 Alloc_ROBEN SHALL combinationally equal End_Index; on VALID_Inst=1 and FULL_FLAG=0 at a rising edge the tail entry SHALL be written busy=1, ready=0, and the tail SHALL advance.
REQ-007 VALID_Inst while FULL_FLAG=1 SHALL be ignored, even if a commit occurs in the same cycle.
REQ-008 A 0..DEPTH occupancy counter SHALL drive FULL_FLAG (count==DEPTH) and EMPTY_FLAG (count==0); simultaneous issue and commit SHALL leave count unchanged.
REQ-009 CDB write with nonzero tag to a busy entry SHALL set ready=1 and store data, decision, exception next edge; writes to non-busy entries SHALL be ignored.
REQ-010 If both CDB ports target the same tag in one cycle, CDB port 1 SHALL win.
REQ-011 Read ports SHALL be combinational: tag 0 or non-busy entry -> data 0, ready 0; busy ready entry -> stored data, ready 1; a same-cycle CDB write to the tag SHALL bypass (data from CDB, ready 1).
REQ-012 When head is busy and ready, the next edge SHALL register Commit_Valid=1 with that entry's fields, clear busy, and advance the head: one commit per cycle, one-cycle latency from ready to commit.
REQ-013 A committing branch (beq/bne) with decision != prediction SHALL assert FLUSH_Flag for one cycle and, on the same edge, clear all busy bits, set both pointers to 1 and count to 0.
REQ-014 A committing entry with exception=1 SHALL assert EXCEPTION_Flag for one cycle and flush identically; Commit_Valid SHALL be 0 for that entry.
REQ-015 Issue and CDB writes in the flush cycle SHALL be discarded.

Reset
REQ-016 rst=1 SHALL immediately clear all busy/ready bits, set Start_Index=End_Index=1, count 0, EMPTY_FLAG=1, FULL_FLAG=0, and all Commit_*, FLUSH_Flag and EXCEPTION_Flag to 0; reset mid-operation SHALL discard all in-flight entries.

Configuration
REQ-017 Macro ROB_DUAL_CDB_EN defined SHALL enable the CDB2_* ports with REQ-009..REQ-011 semantics; undefined, the CDB2_* ports SHALL be absent and behaviour SHALL be single-CDB only.

Verification
REQ-018 Reset, then issue add Rd=10 and add Rd=15 -> Alloc_ROBEN 1, 2; End_Index=3; EMPTY_FLAG=0.
REQ-019 CDB tag 2 data 456, then tag 1 data 123 -> commits in order: Rd 10/123, then Rd 15/456, each with a one-cycle Commit_Valid.
REQ-020 Issue bne with prediction=1 as tag 3; CDB tag 3 decision=0 -> FLUSH_Flag pulse at commit; Start_Index=End_Index=1, EMPTY_FLAG=1.
REQ-021 Issue 17 times with DEPTH=16 -> FULL_FLAG=1 after the 16th; 17th ignored; End_Index wraps to 1.
REQ-022 RP1_ROBEN1=4 while CDB writes tag 4 data 999 -> RP1_Write_Data1=999, RP1_Ready1=1 in the same cycle.
REQ-023 With ROB_DUAL_CDB_EN, both ports write tag 5 (111 vs 222) -> entry holds 111.
